aes128_key_sched: RTL and testbench

Iterative AES-128 key schedule engine. Accepts a 128-bit cipher key and streams round keys 0..10 to the downstream round datapath, one per accepted handshake. Round keys are computed on the fly from the previous one, so there is no 11-entry store. It sits upstream of the AES round pipeline and is the runtime counterpart of the per-round word-transform (RotWord/SubWord/Rcon) logic.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_sbox.sv | 9 +
 rtl/key_round.sv | 21 ++
 rtl/aes128_key_sched.sv | 66 ++++++
 tb/tb_aes128_key_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key schedule types, constants and GF(2^8) helpers.
package aes_pkg;
  localparam int AES128_NUM_RK = 11;
  localparam logic [7:0] RCON_INIT = 8'h01;
  typedef logic [127:0] key_t;
  typedef logic [31:0] word_t;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, r;
    sq = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box for one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = sbox(din);
endmodule

// File: rtl/key_round.sv
// key_round: combinational AES-128 next round key from the current key and rcon.
module key_round
  import aes_pkg::*;
(
  input  key_t       key,
  input  logic [7:0] rcon,
  output key_t       next_key
);
  word_t w0, w1, w2, w3, s, t, w4, w5, w6, w7;
  assign {w0, w1, w2, w3} = key;
  for (genvar b = 0; b < 4; b++) begin : g_sb
    aes_sbox u_sbox (.din(w3[8*b +: 8]), .dout(s[8*b +: 8]));
  end
  // RotWord folded into the byte order of the substituted word
  assign t = {s[23:16] ^ rcon, s[15:8], s[7:0], s[31:24]};
  assign w4 = w0 ^ t;
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};
endmodule

// File: rtl/aes128_key_sched.sv
// aes128_key_sched: iterative AES-128 key schedule streaming round keys 0..10.
// Optional KEY_SCHED_LAST_KEY_EN adds last_key/last_key_valid for the inverse cipher.
module aes128_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready
`ifdef KEY_SCHED_LAST_KEY_EN
  ,
  output logic [127:0] last_key,
  output logic         last_key_valid
`endif
);
  localparam logic [3:0] LAST_IDX = 4'(AES128_NUM_RK - 1);
  state_t state, state_nx;
  logic [7:0] rcon;
  key_t nk;
  logic accept, fire, last;
  key_round u_round (.key(rk_out), .rcon(rcon), .next_key(nk));
  assign key_ready = state == IDLE;
  assign rk_valid = state == EMIT;
  assign accept = key_valid && key_ready;
  assign fire = rk_valid && rk_ready;
  assign last = rk_idx == LAST_IDX;
  always_comb begin
    state_nx = state;
    state_nx = accept ? EMIT : (fire && last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rk_out <= '0;
      rk_idx <= '0;
      rcon <= RCON_INIT;
    end else begin
      state <= state_nx;
      if (accept) begin
        rk_out <= key_in;
        rk_idx <= '0;
        rcon <= RCON_INIT;
      end else if (fire && !last) begin
        rk_out <= nk;
        rk_idx <= rk_idx + 4'd1;
        rcon <= xtime(rcon);
      end
    end
  end
`ifdef KEY_SCHED_LAST_KEY_EN
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      last_key <= '0;
      last_key_valid <= 1'b0;
    end else if (fire && last) begin
      last_key <= rk_out;
      last_key_valid <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_aes128_key_sched.sv
// tb_aes128_key_sched: directed FIPS-197 / zero-key vectors against aes128_key_sched.
module tb_aes128_key_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [127:0] key_in;
  logic key_valid, key_ready, rk_valid, rk_ready;
  logic [127:0] rk_out;
  logic [3:0] rk_idx;
  int errors = 0;
  int checks = 0;
  localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R5 = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
`ifdef KEY_SCHED_LAST_KEY_EN
  logic [127:0] last_key;
  logic last_key_valid;
`endif

  always #5 clk = ~clk;

  aes128_key_sched dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .rk_out(rk_out), .rk_idx(rk_idx),
    .rk_valid(rk_valid), .rk_ready(rk_ready)
`ifdef KEY_SCHED_LAST_KEY_EN
    , .last_key(last_key), .last_key_valid(last_key_valid)
`endif
  );

  // Waits for key_ready, presents k for one accepting edge; returns at the negedge showing idx 0
  task automatic start_key(input logic [127:0] k);
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!key_ready) begin
      errors++;
      $display("FAIL start_key_timeout key_ready=%b required 1", key_ready);
    end
    key_in = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_in = '0;
    rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({key_ready, rk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs ready/valid=%b%b required 10", key_ready, rk_valid);
    end
    checks++;
    if (rk_out !== '0 || rk_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs rk_out=%h idx=%0d required 0/0", rk_out, rk_idx);
    end
`ifdef KEY_SCHED_LAST_KEY_EN
    checks++;
    if (last_key_valid !== 1'b0 || last_key !== '0) begin
      errors++;
      $display("FAIL reset_last last_key_valid=%b required 0", last_key_valid);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_fips_stream();
    logic [127:0] exp;
    rk_ready = 1'b1;
    start_key(FIPS_K);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || key_ready !== 1'b0 || rk_idx !== 4'(i)) begin
        errors++;
        $display("FAIL fips_seq cycle %0d valid=%b ready=%b idx=%0d required 1/0/%0d", i, rk_valid, key_ready, rk_idx, i);
      end
      exp = i == 0 ? FIPS_K : i == 1 ? FIPS_R1 : i == 2 ? FIPS_R2 : i == 5 ? FIPS_R5 : i == 10 ? FIPS_R10 : rk_out;
      if (i == 0 || i == 1 || i == 2 || i == 5 || i == 10) begin
        checks++;
        if (rk_out !== exp) begin
          errors++;
          $display("FAIL fips_rk%0d got %h required %h", i, rk_out, exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({key_ready, rk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL fips_end ready/valid=%b%b required 10", key_ready, rk_valid);
    end
`ifdef KEY_SCHED_LAST_KEY_EN
    checks++;
    if (last_key_valid !== 1'b1 || last_key !== FIPS_R10) begin
      errors++;
      $display("FAIL last_key valid=%b key=%h required 1/%h", last_key_valid, last_key, FIPS_R10);
    end
    start_key('0);
    checks++;
    if (last_key_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_key_clear valid=%b required 0", last_key_valid);
    end
    repeat (11) @(negedge clk);
`endif
  endtask

  task automatic test_back_to_back();
    rk_ready = 1'b1;
    start_key(FIPS_K);
    for (int i = 0; i <= 10; i++) begin
      if (i == 3) begin
        key_in = '0;
        key_valid = 1'b1;
      end
      checks++;
      if (rk_idx !== 4'(i) || key_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idx cycle %0d idx=%0d ready=%b required %0d/0", i, rk_idx, key_ready, i);
      end
      if (i == 10) begin
        checks++;
        if (rk_out !== FIPS_R10) begin
          errors++;
          $display("FAIL b2b_rk10 got %h required %h", rk_out, FIPS_R10);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({key_ready, rk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_gap ready/valid=%b%b required 10", key_ready, rk_valid);
    end
    @(negedge clk);
    key_valid = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk_out !== '0) begin
      errors++;
      $display("FAIL b2b_second valid=%b idx=%0d rk=%h required 1/0/0", rk_valid, rk_idx, rk_out);
    end
    @(negedge clk);
    checks++;
    if (rk_out !== ZERO_R1) begin
      errors++;
      $display("FAIL zero_rk1 got %h required %h", rk_out, ZERO_R1);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (rk_idx !== 4'd10 || rk_out !== ZERO_R10) begin
      errors++;
      $display("FAIL zero_rk10 idx=%0d got %h required 10/%h", rk_idx, rk_out, ZERO_R10);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [127:0] held;
    logic stalled = 1'b0;
    logic done = 1'b0;
    int exp = 0;
    rk_ready = 1'b0;
    start_key(FIPS_K);
    for (int c = 0; c < 300 && !done; c++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(exp)) begin
        errors++;
        $display("FAIL stall_idx valid=%b idx=%0d required 1/%0d", rk_valid, rk_idx, exp);
      end
      if (stalled) begin
        checks++;
        if (rk_out !== held) begin
          errors++;
          $display("FAIL stall_hold got %h required %h", rk_out, held);
        end
      end
      if (exp == 10 && rk_ready == 1'b0 && !stalled) begin
        checks++;
        if (rk_out !== FIPS_R10) begin
          errors++;
          $display("FAIL stall_rk10 got %h required %h", rk_out, FIPS_R10);
        end
      end
      held = rk_out;
      rk_ready = 1'($urandom % 2);
      stalled = !rk_ready;
      if (rk_ready) begin
        if (exp == 10) done = 1'b1;
        else exp++;
      end
      @(negedge clk);
    end
    checks++;
    if (!done || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_end done=%b ready=%b required 1/1", done, key_ready);
    end
    rk_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    rk_ready = 1'b1;
    start_key(FIPS_K);
    repeat (5) @(negedge clk);
    checks++;
    if (rk_idx !== 4'd5 || rk_out !== FIPS_R5) begin
      errors++;
      $display("FAIL mid_pre idx=%0d rk=%h required 5/%h", rk_idx, rk_out, FIPS_R5);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({key_ready, rk_valid} !== 2'b10 || rk_out !== '0) begin
      errors++;
      $display("FAIL mid_reset ready/valid=%b%b rk=%h required 10/0", key_ready, rk_valid, rk_out);
    end
    rst_n = 1'b1;
    start_key('0);
    checks++;
    if (rk_idx !== 4'd0 || rk_out !== '0) begin
      errors++;
      $display("FAIL mid_restart idx=%0d rk=%h required 0/0", rk_idx, rk_out);
    end
    @(negedge clk);
    checks++;
    if (rk_idx !== 4'd1 || rk_out !== ZERO_R1) begin
      errors++;
      $display("FAIL mid_rcon idx=%0d rk=%h required 1/%h", rk_idx, rk_out, ZERO_R1);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fips_stream();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
